operand_fetch_stage: RTL and testbench
======================================

Name: operand_fetch_stage

Overview:
- Parametrised successor to the single-shot rs1/rs2 operand latches.
- Owns the architectural register file and a per-register busy scoreboard.
- Selects operand A/B from register or decoded immediate; stalls on RAW hazards and forwards same-cycle write-back.
- Presents operands through a registered valid/ready output stage between decode and execute.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, number of architectural registers; x0 hardwired to zero.
- AW, $clog2(NREGS), register address width (derived; not overridden).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- in_valid  input  1  decoded instruction present
- in_ready  output  1  stage accepts instruction this cycle
- in_rs1  input  AW  source 1 address
- in_rs2  input  AW  source 2 address
- in_rs1_used  input  1  rs1 is a real source
- in_rs2_used  input  1  rs2 is a real source
- in_rd  input  AW  destination address
- in_rd_we  input  1  instruction writes rd
- in_imm  input  XLEN  decoded immediate
- in_opa_imm  input  1  op_a = in_imm instead of rs1 data
- in_opb_imm  input  1  op_b = in_imm instead of rs2 data
- wb_en  input  1  write-back strobe
- wb_addr  input  AW  write-back register
- wb_data  input  XLEN  write-back value
- flush  input  1  squash output entry and clear scoreboard
- out_valid  output  1  operands valid
- out_ready  input  1  execute accepts
- out_op_a  output  XLEN  operand A
- out_op_b  output  XLEN  operand B
- out_rs2_data  output  XLEN  raw rs2 value (store data)
- out_rd  output  AW  destination
- out_rd_we  output  1  destination write enable

Behaviour:
- Reset (rst low, async): register array, busy[] and all out_* registers are 0; out_valid=0.
- Array write: on clk when wb_en && wb_addr!=0. Writes to x0 are ignored; reads of x0 always return 0.
- Hazard: hz = in_valid && ((in_rs1_used && rs1!=0 && busy[rs1] && !byp1) || (in_rs2_used && rs2!=0 && busy[rs2] && !byp2)).
  - byp_n = wb_en && wb_addr==rs_n (feature-dependent, see Optional Feature).
- Handshake:
  - in_ready = (!out_valid || out_ready) && !hz && !flush.
  - fire = in_valid && in_ready.
- Latency: 1 cycle. On fire, out_* load on the next edge and out_valid=1.
  - If out_ready && !fire, out_valid clears.
  - If !out_ready, out_* hold stable.
- Read data: source value = wb_data when bypassing, else array[rs]. op_a/op_b are muxed with in_imm per in_opa_imm/in_opb_imm.
- Scoreboard:
  - Fire with in_rd_we && in_rd!=0 sets busy[in_rd].
  - wb_en clears busy[wb_addr].
  - Same-cycle set and clear of the same register: set wins.
- flush: next edge out_valid=0, all busy[] cleared, no fire that cycle. Array contents retained.
  - Contract: asserted only when no older writer remains downstream, except same-cycle wb, which is still written to the array.
- in_* may change freely while in_ready=0. No state depends on stalled inputs.

Optional Feature:
- Macro OFS_WB_BYPASS_EN.
- Defined: byp_n as above; same-cycle write-back forwarded, no stall.
- Undefined: byp_n=0; the consumer stalls one extra cycle and reads from the array after the write.

Decomposition:
- Package ofs_pkg: XLEN/NREGS defaults, AW function, reg-address typedef, X0 constant.
- Sub-module ofs_scoreboard: NREGS busy bits; ports set_en/set_addr, clr_en/clr_addr, clear_all, two query addresses returning busy.

Test Plan:
- Reset: rst low mid-traffic -> out_valid=0, outputs 0 immediately; reads of any register return 0 after release.
- Basic: wb x5=0x1234 in cycle 0; cycle 2 issue rs1=5, rs2=0, opb_imm, imm=0xFFFFFFF0 -> next cycle out_op_a=0x1234, out_op_b=0xFFFFFFF0, out_valid=1.
- RAW stall: issue rd=7 we=1, then consumer rs1=7 -> in_ready=0 until wb_addr=7 data=0xAA.
  - With bypass: fires that cycle, out_op_a=0xAA.
  - Without bypass: fires the next cycle.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_* stable; out_ready=1 -> one transfer per cycle.
- x0 and collision: wb x0=0xDEAD -> reads 0. Same-cycle issue rd=3 and wb_addr=3 -> busy[3]=1 afterwards.
- Flush: busy[4]=1, out_valid=1, flush=1 -> next cycle out_valid=0, rs1=4 consumer fires without stall.

Source files
------------

// File: rtl/ofs_pkg.sv
// Shared sizing, register-address type and the hardwired-zero register index
// for the operand fetch stage.
package ofs_pkg;

  localparam int OFS_XLEN  = 32;
  localparam int OFS_NREGS = 32;

  function automatic int ofs_aw(input int nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

  localparam int OFS_AW = ofs_aw(OFS_NREGS);

  typedef logic [OFS_AW-1:0] reg_addr_t;

  localparam reg_addr_t X0 = '0;

endpackage

// File: rtl/ofs_scoreboard.sv
// Per-register busy bits tracking in-flight writers; a set on the same edge
// as a clear of the same register leaves the register busy.
module ofs_scoreboard
  import ofs_pkg::*;
#(
  parameter  int NREGS = OFS_NREGS,
  localparam int AW    = ofs_aw(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic          clear_all,
  input  logic [AW-1:0] q1_addr,
  input  logic [AW-1:0] q2_addr,
  output logic          q1_busy,
  output logic          q2_busy
);

  logic [NREGS-1:0] r_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
    end else if (clear_all) begin
      r_busy <= '0;
    end else begin
      if (clr_en) r_busy[clr_addr] <= 1'b0;
      if (set_en) r_busy[set_addr] <= 1'b1;
    end
  end

  assign q1_busy = r_busy[q1_addr];
  assign q2_busy = r_busy[q2_addr];

endmodule

// File: rtl/operand_fetch_stage.sv
// Register file, RAW scoreboard and registered valid/ready operand stage.
// Build option: define OFS_WB_BYPASS_EN to forward same-cycle write-back.
module operand_fetch_stage
  import ofs_pkg::*;
#(
  parameter  int XLEN  = OFS_XLEN,
  parameter  int NREGS = OFS_NREGS,
  localparam int AW    = ofs_aw(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   in_rs1,
  input  logic [AW-1:0]   in_rs2,
  input  logic            in_rs1_used,
  input  logic            in_rs2_used,
  input  logic [AW-1:0]   in_rd,
  input  logic            in_rd_we,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_opa_imm,
  input  logic            in_opb_imm,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_op_a,
  output logic [XLEN-1:0] out_op_b,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [AW-1:0]   out_rd,
  output logic            out_rd_we
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(X0);

  logic [XLEN-1:0] r_regs [NREGS];

  logic            r_out_valid;
  logic [XLEN-1:0] r_out_op_a;
  logic [XLEN-1:0] r_out_op_b;
  logic [XLEN-1:0] r_out_rs2_data;
  logic [AW-1:0]   r_out_rd;
  logic            r_out_rd_we;

  logic            w_rs1_nz, w_rs2_nz;
  logic            w_busy1, w_busy2;
  logic            w_byp1, w_byp2;
  logic            w_hz, w_fire;
  logic [XLEN-1:0] w_rs1_val, w_rs2_val;

  assign w_rs1_nz = (in_rs1 != ZERO_ADDR);
  assign w_rs2_nz = (in_rs2 != ZERO_ADDR);

`ifdef OFS_WB_BYPASS_EN
  assign w_byp1 = wb_en && (wb_addr == in_rs1);
  assign w_byp2 = wb_en && (wb_addr == in_rs2);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (wb_en && (wb_addr != ZERO_ADDR)) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  ofs_scoreboard #(.NREGS(NREGS)) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_en    (w_fire && in_rd_we && (in_rd != ZERO_ADDR)),
    .set_addr  (in_rd),
    .clr_en    (wb_en),
    .clr_addr  (wb_addr),
    .clear_all (flush),
    .q1_addr   (in_rs1),
    .q2_addr   (in_rs2),
    .q1_busy   (w_busy1),
    .q2_busy   (w_busy2)
  );

  assign w_hz = in_valid &&
                ((in_rs1_used && w_rs1_nz && w_busy1 && !w_byp1) ||
                 (in_rs2_used && w_rs2_nz && w_busy2 && !w_byp2));

  assign in_ready = (!r_out_valid || out_ready) && !w_hz && !flush;
  assign w_fire   = in_valid && in_ready;

  // x0 check comes first so a forwarded write to x0 can never leak through.
  assign w_rs1_val = !w_rs1_nz ? '0 : (w_byp1 ? wb_data : r_regs[in_rs1]);
  assign w_rs2_val = !w_rs2_nz ? '0 : (w_byp2 ? wb_data : r_regs[in_rs2]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid    <= 1'b0;
      r_out_op_a     <= '0;
      r_out_op_b     <= '0;
      r_out_rs2_data <= '0;
      r_out_rd       <= '0;
      r_out_rd_we    <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_fire) begin
      r_out_valid    <= 1'b1;
      r_out_op_a     <= in_opa_imm ? in_imm : w_rs1_val;
      r_out_op_b     <= in_opb_imm ? in_imm : w_rs2_val;
      r_out_rs2_data <= w_rs2_val;
      r_out_rd       <= in_rd;
      r_out_rd_we    <= in_rd_we;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid    = r_out_valid;
  assign out_op_a     = r_out_op_a;
  assign out_op_b     = r_out_op_b;
  assign out_rs2_data = r_out_rs2_data;
  assign out_rd       = r_out_rd;
  assign out_rd_we    = r_out_rd_we;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench for operand_fetch_stage; expectations follow OFS_WB_BYPASS_EN.
module tb_operand_fetch_stage;

`ifdef OFS_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_rs1_used, in_rs2_used, in_rd_we;
  logic [31:0] in_imm;
  logic        in_opa_imm, in_opb_imm;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_op_a, out_op_b, out_rs2_data;
  logic [4:0]  out_rd;
  logic        out_rd_we;

  typedef struct packed {
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic        rd_we;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mdl[32];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  operand_fetch_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used),
    .in_rd(in_rd), .in_rd_we(in_rd_we), .in_imm(in_imm),
    .in_opa_imm(in_opa_imm), .in_opb_imm(in_opb_imm),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op_a(out_op_a), .out_op_b(out_op_b), .out_rs2_data(out_rs2_data),
    .out_rd(out_rd), .out_rd_we(out_rd_we)
  );

  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (BYP && wb_en && wb_addr == a) return wb_data;
    return mdl[a];
  endfunction

  // Monitor: compare transfers, record fires, then apply write-back to the model.
  always @(negedge clk) begin
    if (rst) begin
      if (flush) begin
        exp_q.delete();
      end else if (out_valid && out_ready) begin
        exp_t e, got;
        checks++;
        got = '{out_op_a, out_op_b, out_rs2_data, out_rd, out_rd_we};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL xfer_unexpected: got a=%h b=%h, required no transfer", out_op_a, out_op_b);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL xfer_data: got a=%h b=%h s=%h rd=%0d we=%b, required a=%h b=%h s=%h rd=%0d we=%b",
                     got.op_a, got.op_b, got.rs2_data, got.rd, got.rd_we,
                     e.op_a, e.op_b, e.rs2_data, e.rd, e.rd_we);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_t n;
        n.rs2_data = in_rs2_used ? mread(in_rs2) : mread(in_rs2);
        n.op_a     = in_opa_imm ? in_imm : mread(in_rs1);
        n.op_b     = in_opb_imm ? in_imm : n.rs2_data;
        n.rd       = in_rd;
        n.rd_we    = in_rd_we;
        exp_q.push_back(n);
      end
      if (wb_en && wb_addr != 5'd0) mdl[wb_addr] = wb_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rs1_used = 0; in_rs2_used = 0;
    in_rd = 0; in_rd_we = 0; in_imm = 0; in_opa_imm = 0; in_opb_imm = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0; flush = 0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic we,
                       input logic [31:0] imm, input logic ai, input logic bi);
    in_valid = 1; in_rs1 = rs1; in_rs1_used = u1; in_rs2 = rs2; in_rs2_used = u2;
    in_rd = rd; in_rd_we = we; in_imm = imm; in_opa_imm = ai; in_opb_imm = bi;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1; wb_addr = a; wb_data = d;
  endtask

  task automatic test_reset();
    rst = 0; out_ready = 0; clr_in();
    for (int i = 0; i < 32; i++) mdl[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_op_a !== 32'h0 || out_op_b !== 32'h0 || out_rd_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b a=%h b=%h we=%b, required all 0", out_valid, out_op_a, out_op_b, out_rd_we);
    end
    rst = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    step();
    wb(5, 32'h55);
    step();
    clr_in();
    issue(5, 1, 0, 0, 9, 0, 0, 0, 0);
    step();
    clr_in();
    checks++;
    if (out_valid !== 1'b1 || out_op_a !== 32'h55) begin
      errors++; $display("FAIL reset_pre_traffic: got v=%b a=%h, required v=1 a=00000055", out_valid, out_op_a);
    end
    #2 rst = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_op_a !== 32'h0 || out_rd !== 5'd0) begin
      errors++; $display("FAIL reset_async: got v=%b a=%h rd=%0d, required 0", out_valid, out_op_a, out_rd);
    end
    exp_q.delete();
    for (int i = 0; i < 32; i++) mdl[i] = 0;
    @(posedge clk);
    #1 rst = 1;
    out_ready = 1;
    issue(5, 1, 5, 1, 0, 0, 0, 0, 0);
    step();
    clr_in();
    checks++;
    if (out_valid !== 1'b1 || out_op_a !== 32'h0 || out_rs2_data !== 32'h0) begin
      errors++; $display("FAIL reset_array_clear: got v=%b a=%h s=%h, required v=1 a=0 s=0", out_valid, out_op_a, out_rs2_data);
    end
    step();
  endtask

  task automatic test_basic();
    out_ready = 1;
    wb(5, 32'h1234);
    step();
    clr_in();
    step();
    issue(5, 1, 0, 0, 0, 0, 32'hFFFF_FFF0, 0, 1);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL basic_in_ready: got %b, required 1", in_ready);
    end
    step();
    clr_in();
    checks++;
    if (out_valid !== 1'b1 || out_op_a !== 32'h1234 || out_op_b !== 32'hFFFF_FFF0) begin
      errors++; $display("FAIL basic_operands: got v=%b a=%h b=%h, required v=1 a=00001234 b=fffffff0", out_valid, out_op_a, out_op_b);
    end
    step();
  endtask

  task automatic test_raw_stall();
    out_ready = 1;
    issue(0, 0, 0, 0, 7, 1, 0, 0, 0);
    step();
    issue(7, 1, 0, 0, 8, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL raw_stall_%0d: got in_ready=%b, required 0", i, in_ready);
      end
      step();
    end
    wb(7, 32'hAA);
    #1;
    checks++;
    if (in_ready !== BYP) begin
      errors++; $display("FAIL raw_release: got in_ready=%b, required %b", in_ready, BYP);
    end
    if (!BYP) begin
      step();
      wb_en = 0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL raw_late_fire: got in_ready=%b, required 1", in_ready);
      end
    end
    step();
    clr_in();
    checks++;
    if (out_valid !== 1'b1 || out_op_a !== 32'hAA) begin
      errors++; $display("FAIL raw_operand: got v=%b a=%h, required v=1 a=000000aa", out_valid, out_op_a);
    end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    issue(5, 1, 7, 1, 0, 0, 0, 0, 0);
    step();
    issue(7, 1, 0, 0, 0, 0, 32'h10, 0, 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_op_a !== 32'h1234 || out_op_b !== 32'hAA) begin
        errors++;
        $display("FAIL bp_hold_%0d: got rdy=%b v=%b a=%h b=%h, required rdy=0 v=1 a=00001234 b=000000aa",
                 i, in_ready, out_valid, out_op_a, out_op_b);
      end
      step();
    end
    out_ready = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_resume: got in_ready=%b, required 1", in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_op_a !== 32'hAA || out_op_b !== 32'h10) begin
      errors++; $display("FAIL bp_second: got v=%b a=%h b=%h, required v=1 a=000000aa b=00000010", out_valid, out_op_a, out_op_b);
    end
    issue(0, 0, 5, 1, 0, 0, 32'h20, 1, 0);
    step();
    clr_in();
    checks++;
    if (out_valid !== 1'b1 || out_op_a !== 32'h20 || out_op_b !== 32'h1234) begin
      errors++; $display("FAIL bp_third: got v=%b a=%h b=%h, required v=1 a=00000020 b=00001234", out_valid, out_op_a, out_op_b);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain: got v=%b, required 0", out_valid);
    end
  endtask

  task automatic test_x0_collision();
    out_ready = 1;
    wb(0, 32'hDEAD);
    step();
    clr_in();
    issue(0, 1, 0, 1, 0, 0, 0, 0, 0);
    step();
    clr_in();
    checks++;
    if (out_op_a !== 32'h0 || out_op_b !== 32'h0 || out_rs2_data !== 32'h0) begin
      errors++; $display("FAIL x0_read: got a=%h b=%h s=%h, required 0", out_op_a, out_op_b, out_rs2_data);
    end
    issue(0, 0, 0, 0, 3, 1, 0, 0, 0);
    wb(3, 32'h33);
    step();
    clr_in();
    issue(3, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL collision_busy_%0d: got in_ready=%b, required 0", i, in_ready);
      end
      step();
    end
    wb(3, 32'h77);
    begin
      int n = 0;
      #1;
      while (!in_ready && n < 5) begin
        step();
        wb_en = 0;
        n++;
      end
      checks++;
      if (n !== (BYP ? 0 : 1)) begin
        errors++; $display("FAIL collision_release: got %0d wait cycles, required %0d", n, BYP ? 0 : 1);
      end
    end
    step();
    clr_in();
    checks++;
    if (out_op_a !== 32'h77) begin
      errors++; $display("FAIL collision_value: got a=%h, required 00000077", out_op_a);
    end
    step();
  endtask

  task automatic test_flush();
    out_ready = 0;
    issue(0, 0, 0, 0, 4, 1, 0, 0, 0);
    step();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL flush_setup: got v=%b, required 1", out_valid);
    end
    issue(4, 1, 0, 0, 0, 0, 0, 0, 0);
    flush = 1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_no_fire: got in_ready=%b, required 0", in_ready);
    end
    step();
    flush = 0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_squash: got v=%b, required 0", out_valid);
    end
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_busy_clear: got in_ready=%b, required 1", in_ready);
    end
    out_ready = 1;
    step();
    clr_in();
    checks++;
    if (out_valid !== 1'b1 || out_op_a !== 32'h0) begin
      errors++; $display("FAIL flush_consumer: got v=%b a=%h, required v=1 a=0", out_valid, out_op_a);
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_raw_stall();
    test_backpressure();
    test_x0_collision();
    test_flush();
    repeat (2) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL queue_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
